tcm_port_arbiter: RTL
=====================

TCM_PORT_ARBITER -- requirements
Module: tcm_port_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32: byte address width.
REQ-002 Parameter DATA_WIDTH, default 32: write/read data width; bytes = DATA_WIDTH/8.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid[k], k=0..1  input  1 each  requester k presents an op; port 0 is the store buffer, port 1 is the debug/loader master.
REQ-006 req_we[k]  input  1 each  1 = write, 0 = read.
REQ-007 req_addr[k]  input  ADDR_WIDTH each  byte address.
REQ-008 req_size[k]  input  3 each  access size in bytes; legal values 1, 2, 4.
REQ-009 req_wdata[k]  input  DATA_WIDTH each  write data, byte 0 in bits [7:0].
REQ-010 req_ready[k]  output  1 each  op accepted this cycle when req_valid[k] is also 1.
REQ-011 rsp_valid[k]  output  1 each  read data or error returned to requester k.
REQ-012 rsp_rdata  output  DATA_WIDTH  read data shared by both requesters, qualified by rsp_valid[k].
REQ-013 rsp_err  output  1  the rsp_valid pulse reports an illegal-size op.
REQ-014 tcm_rd, tcm_read_addr, tcm_read_size  output  1/ADDR_WIDTH/3  TCM read port.
REQ-015 tcm_wr, tcm_write_addr, tcm_write_size, tcm_wdata  output  1/ADDR_WIDTH/3/DATA_WIDTH  TCM write port.
REQ-016 tcm_rdata  input  DATA_WIDTH  TCM read data, valid the cycle after tcm_rd.

Function
REQ-017 Read and write ports SHALL be arbitrated independently each cycle; a read from one requester and a write from the other SHALL both be granted in the same cycle.
REQ-018 Per port, one grant per cycle; if only one requester contends, it SHALL be granted.
REQ-019 On contention, the requester indicated by that port's round-robin pointer (rr_rd, rr_wr) SHALL win; the pointer SHALL then move to the loser. Uncontended grants SHALL NOT move the pointer.
REQ-020 req_ready[k] SHALL be combinational, asserted exactly when k's op is granted; no op SHALL be accepted without req_valid.
REQ-021 Granted legal read: tcm_rd=1, tcm_read_addr/size from the winner, same cycle. Granted legal write: tcm_wr=1 with the winner's addr/size/wdata, same cycle.
REQ-022 Read latency SHALL be exactly 1 cycle: rsp_valid[owner]=1 and rsp_rdata=tcm_rdata the cycle after the grant, where owner is registered at grant.
REQ-023 Responses SHALL have no backpressure; back-to-back reads by one requester SHALL be accepted every cycle.
REQ-024 Illegal size (not 1, 2, 4): the op SHALL be accepted (req_ready=1), no TCM strobe issued, and the next cycle rsp_valid[k]=1 with rsp_err=1 and rsp_rdata=0, for reads and writes.
REQ-025 Legal writes SHALL produce no response.
REQ-026 The read error pulse and the read data pulse share the same response slot and SHALL NOT collide (one read grant per cycle).
REQ-027 A write error response and a read data response in the same cycle SHALL be resolved by stalling: a write with illegal size SHALL NOT be granted in a cycle that also grants a read, and SHALL be granted in the next non-read cycle.
REQ-028 When tcm_rd/tcm_wr are 0, the corresponding address/size/data outputs SHALL be 0.

Reset
REQ-029 While rst=1: req_ready=0, tcm_rd=0, tcm_wr=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, rr_rd=rr_wr=0, pending response cleared.
REQ-030 A read granted in the cycle before rst rises SHALL NOT produce rsp_valid in the reset cycle.
REQ-031 First cycle after rst falls SHALL arbitrate normally, with requester 0 winning first contention.

Verification
REQ-032 Both requesters read continuously (addr 0x100 and 0x200, size 4) -> grants alternate 0,1,0,1; each rsp_valid one cycle after its grant with matching tcm_rdata.
REQ-033 Req0 writes 0x10 (size 4, 0xDEADBEEF) while req1 reads 0x20 in the same cycle -> tcm_wr and tcm_rd both 1; req1 rsp_valid next cycle.
REQ-034 Req1 issues a size-3 read -> req_ready[1]=1, no tcm_rd, next cycle rsp_valid[1]=1, rsp_err=1, rsp_rdata=0.
REQ-035 Req0 issues a size-3 write while req1 reads -> read granted first; write granted the following cycle; the error pulse arrives one cycle later with no overlap.
REQ-036 Read granted, rst asserted the next cycle -> no rsp_valid; after release, first contention is won by req0.
REQ-037 Only req1 is active for 5 cycles, then both contend -> req0 wins (pointer unchanged by the uncontended grants).

Source files
------------

// File: rtl/tcm_port_arbiter.sv
// ---------------------------------------------------------------------------
// tcm_port_arbiter
//
// Shares the single-read / single-write port pair of a tightly coupled memory
// between two requesters: requester 0 is the store buffer, requester 1 is the
// debug/loader master. The read and write ports are arbitrated independently,
// so one requester's read and the other's write can be granted together.
// Each port has its own round-robin pointer. The pointer only moves when both
// requesters contend for that port.
//
// Ops with an illegal size (anything but 1, 2 or 4 bytes) are still accepted.
// They never reach the TCM. Instead, an error response is returned one cycle
// later through the shared response slot.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   req_valid_i[k]            requester k presents an op
//   req_we_i[k]               1 = write, 0 = read
//   req_addr_i[k]             byte address
//   req_size_i[k]             access size in bytes (1, 2, 4 legal)
//   req_wdata_i[k]            write data, byte 0 in [7:0]
//   req_ready_o[k]            op of requester k accepted this cycle (combinational)
//   rsp_valid_o[k]            response for requester k this cycle
//   rsp_rdata_o               read data, shared, qualified by rsp_valid_o
//   rsp_err_o                 current response reports an illegal-size op
//   tcm_rd_o / tcm_read_*     TCM read strobe, address, size
//   tcm_wr_o / tcm_write_*    TCM write strobe, address, size, data
//   tcm_rdata_i               TCM read data, valid the cycle after tcm_rd_o
// ---------------------------------------------------------------------------
module tcm_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst,

    input  logic [1:0]                  req_valid_i,
    input  logic [1:0]                  req_we_i,
    input  logic [1:0][ADDR_WIDTH-1:0]  req_addr_i,
    input  logic [1:0][2:0]             req_size_i,
    input  logic [1:0][DATA_WIDTH-1:0]  req_wdata_i,
    output logic [1:0]                  req_ready_o,

    output logic [1:0]                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                        rsp_err_o,

    output logic                        tcm_rd_o,
    output logic [ADDR_WIDTH-1:0]       tcm_read_addr_o,
    output logic [2:0]                  tcm_read_size_o,

    output logic                        tcm_wr_o,
    output logic [ADDR_WIDTH-1:0]       tcm_write_addr_o,
    output logic [2:0]                  tcm_write_size_o,
    output logic [DATA_WIDTH-1:0]       tcm_wdata_o,

    input  logic [DATA_WIDTH-1:0]       tcm_rdata_i
);

    // Round-robin pointers: value is the requester that wins the next contention.
    logic rr_rd_q, rr_rd_d;
    logic rr_wr_q, rr_wr_d;

    // Single response slot, filled at grant time and returned the next cycle.
    logic rsp_pend_q,  rsp_pend_d;
    logic rsp_owner_q, rsp_owner_d;
    logic rsp_err_q,   rsp_err_d;

    logic [1:0] size_ok;
    logic [1:0] rd_cand;
    logic [1:0] wr_cand;
    logic [1:0] rd_gnt;
    logic [1:0] wr_gnt;
    logic       rd_any;
    logic       wr_any;
    logic       rd_win;
    logic       wr_win;

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            size_ok[k] = (req_size_i[k] == 3'd1) ||
                         (req_size_i[k] == 3'd2) ||
                         (req_size_i[k] == 3'd4);
        end
    end

    // Read port arbitration. Illegal-size reads arbitrate here too, because
    // their error pulse uses the read response slot.
    always_comb begin
        rd_cand = req_valid_i & ~req_we_i & {2{~rst}};
        rr_rd_d = rr_rd_q;
        rd_gnt  = rd_cand;
        if (rd_cand == 2'b11) begin
            rd_gnt  = rr_rd_q ? 2'b10 : 2'b01;
            rr_rd_d = ~rr_rd_q;
        end
        rd_any = |rd_gnt;
        rd_win = rd_gnt[1];
    end

    // Write port arbitration. An illegal-size write needs the response slot.
    // It is held off in any cycle that grants a read, so that its error pulse
    // can never land on top of read data.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            wr_cand[k] = req_valid_i[k] & req_we_i[k] & ~rst &
                         (size_ok[k] | ~rd_any);
        end
        rr_wr_d = rr_wr_q;
        wr_gnt  = wr_cand;
        if (wr_cand == 2'b11) begin
            wr_gnt  = rr_wr_q ? 2'b10 : 2'b01;
            rr_wr_d = ~rr_wr_q;
        end
        wr_any = |wr_gnt;
        wr_win = wr_gnt[1];
    end

    assign req_ready_o = rd_gnt | wr_gnt;

    // TCM strobes go out only for legal sizes. The unused address, size and
    // data fields are forced to zero.
    always_comb begin
        tcm_rd_o         = rd_any & size_ok[rd_win];
        tcm_read_addr_o  = '0;
        tcm_read_size_o  = '0;
        if (tcm_rd_o) begin
            tcm_read_addr_o = req_addr_i[rd_win];
            tcm_read_size_o = req_size_i[rd_win];
        end

        tcm_wr_o         = wr_any & size_ok[wr_win];
        tcm_write_addr_o = '0;
        tcm_write_size_o = '0;
        tcm_wdata_o      = '0;
        if (tcm_wr_o) begin
            tcm_write_addr_o = req_addr_i[wr_win];
            tcm_write_size_o = req_size_i[wr_win];
            tcm_wdata_o      = req_wdata_i[wr_win];
        end
    end

    // At most one response is created per cycle: every read grant creates one,
    // and an illegal write is only granted when no read is granted.
    always_comb begin
        rsp_pend_d  = 1'b0;
        rsp_owner_d = 1'b0;
        rsp_err_d   = 1'b0;
        if (rd_any) begin
            rsp_pend_d  = 1'b1;
            rsp_owner_d = rd_win;
            rsp_err_d   = ~size_ok[rd_win];
        end else if (wr_any && !size_ok[wr_win]) begin
            rsp_pend_d  = 1'b1;
            rsp_owner_d = wr_win;
            rsp_err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_rd_q     <= 1'b0;
            rr_wr_q     <= 1'b0;
            rsp_pend_q  <= 1'b0;
            rsp_owner_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            rr_rd_q     <= rr_rd_d;
            rr_wr_q     <= rr_wr_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_owner_q <= rsp_owner_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Gating with rst suppresses a response left over from a read granted the
    // cycle before reset rose. The register itself is only cleared at the
    // first reset edge.
    always_comb begin
        rsp_valid_o = 2'b00;
        rsp_err_o   = 1'b0;
        rsp_rdata_o = '0;
        if (rsp_pend_q && !rst) begin
            rsp_valid_o = rsp_owner_q ? 2'b10 : 2'b01;
            rsp_err_o   = rsp_err_q;
            if (!rsp_err_q) begin
                rsp_rdata_o = tcm_rdata_i;
            end
        end
    end

endmodule
